// File: rtl/if1_pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// if1_pc_gen_pkg
//   Shared definitions for the IF1 fetch stage: IF1->IF2 bus width and field
//   offsets, the stall bus type, and small address/counter helpers.
// -----------------------------------------------------------------------------
package if1_pc_gen_pkg;

    // IF1 -> IF2 bus: {valid, pc[31:0], pred_taken, pred_target[31:0]}
    localparam int IF12IF2_WD     = 66;
    localparam int IF1_VALID_BIT  = 65;
    localparam int IF1_PC_HI      = 64;
    localparam int IF1_PC_LO      = 33;
    localparam int PRED_TAKEN_BIT = 32;
    localparam int PRED_TGT_HI    = 31;
    localparam int PRED_TGT_LO    = 0;

    // Pipeline stall bus; IF1 only looks at bit 0.
    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_bus_t;

    // Sequential fetch address, modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Saturating 32-bit increment for the performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if1_pc_gen_btb.sv
// -----------------------------------------------------------------------------
// if1_btb
//   Direct-mapped branch target buffer for IF1.
//   Lookup is purely combinational on the registered arrays, so an update and a
//   lookup to the same index in one cycle see the old contents.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset (clears valid bits)
//   lookup_pc [31:2]  : word address being fetched
//   hit               : valid entry with matching tag
//   hit_target        : predicted target (word aligned)
//   upd_we            : update strobe from EX
//   upd_pc    [31:2]  : PC of the resolved control-flow instruction
//   upd_target[31:2]  : resolved target
//   upd_taken         : 1 = install/replace, 0 = invalidate on tag match
// -----------------------------------------------------------------------------
module if1_btb #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] lookup_pc,
    output logic        hit,
    output logic [31:0] hit_target,
    input  logic        upd_we,
    input  logic [31:2] upd_pc,
    input  logic [31:2] upd_target,
    input  logic        upd_taken
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [29:0]            target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign hit_target = {target_q[lk_idx], 2'b00};

    // Valid bits: reset-cleared; a not-taken update only drops an entry that
    // actually belongs to that PC, so an aliasing branch cannot evict it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd_we) begin
            if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
            end else if (tag_q[up_idx] == up_tag) begin
                valid_q[up_idx] <= 1'b0;
            end
        end
    end

    // Tag/target storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!rst && upd_we && upd_taken) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/if1_pc_gen.sv
// -----------------------------------------------------------------------------
// if1_pc_gen
//   First fetch stage: holds the fetch PC, drives the instruction SRAM read
//   and predicts the next PC through a direct-mapped BTB (if1_btb).
//   EX mispredicts (br_e/br_addr) override everything except reset.
//
// Optional feature: define IF1_PERF_CNT_EN to add saturating fetch and
// redirect counters (perf_fetch_cnt, perf_redirect_cnt).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   stall           : stall bus, bit 0 freezes IF1
//   br_e, br_addr   : redirect from EX (br_addr[1:0] ignored)
//   btb_we, btb_pc, btb_target, btb_taken : BTB update from EX
//   inst_sram_en/we/addr : instruction SRAM read request (we tied low)
//   if12if2_bus     : {valid, pc, pred_taken, pred_target} to IF2
//   perf_fetch_cnt, perf_redirect_cnt : only with IF1_PERF_CNT_EN
// -----------------------------------------------------------------------------
module if1_pc_gen
    import if1_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  stall_bus_t            stall,
    input  logic                  br_e,
    input  logic [31:0]           br_addr,
    input  logic                  btb_we,
    input  logic [31:0]           btb_pc,
    input  logic [31:0]           btb_target,
    input  logic                  btb_taken,
    output logic                  inst_sram_en,
    output logic [3:0]            inst_sram_we,
    output logic [31:0]           inst_sram_addr,
    output logic [IF12IF2_WD-1:0] if12if2_bus
`ifdef IF1_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_redirect_cnt
`endif
);

    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        btb_hit;
    logic [31:0] btb_hit_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        fetch_valid;

    // Low address bits and the upper stall bits are deliberately not consumed.
    logic unused_bits;
    assign unused_bits = ^{br_addr[1:0], btb_pc[1:0], btb_target[1:0],
                           stall[STALL_W-1:1]};

    if1_btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (pc_q[31:2]),
        .hit        (btb_hit),
        .hit_target (btb_hit_target),
        .upd_we     (btb_we),
        .upd_pc     (btb_pc[31:2]),
        .upd_target (btb_target[31:2]),
        .upd_taken  (btb_taken)
    );

    assign pred_taken  = btb_hit;
    assign pred_target = btb_hit ? btb_hit_target : pc_plus4(pc_q);

    // A redirect wins over stall so a mispredict under stall replaces the held PC.
    always_comb begin
        next_pc = pred_target;
        if (br_e) begin
            next_pc = {br_addr[31:2], 2'b00};
        end else if (stall[0]) begin
            next_pc = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    // The slot fetched in a redirect cycle is squashed: IF2 flushes on that edge.
    assign fetch_valid    = !rst && !stall[0] && !br_e;
    assign inst_sram_en   = fetch_valid;
    assign inst_sram_we   = 4'b0000;
    assign inst_sram_addr = pc_q;

    assign if12if2_bus[IF1_VALID_BIT]             = fetch_valid;
    assign if12if2_bus[IF1_PC_HI:IF1_PC_LO]       = pc_q;
    assign if12if2_bus[PRED_TAKEN_BIT]            = pred_taken;
    assign if12if2_bus[PRED_TGT_HI:PRED_TGT_LO]   = pred_target;

`ifdef IF1_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (fetch_valid) begin
                perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            end
            if (br_e) begin
                perf_redirect_cnt <= sat_inc(perf_redirect_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_if1_pc_gen.sv
module tb_if1_pc_gen;
    import if1_pc_gen_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    stall_bus_t  stall;
    logic        br_e;
    logic [31:0] br_addr;
    logic        btb_we;
    logic [31:0] btb_pc;
    logic [31:0] btb_target;
    logic        btb_taken;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [65:0] if12if2_bus;
`ifdef IF1_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    if1_pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_e           (br_e),
        .br_addr        (br_addr),
        .btb_we         (btb_we),
        .btb_pc         (btb_pc),
        .btb_target     (btb_target),
        .btb_taken      (btb_taken),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .if12if2_bus    (if12if2_bus)
`ifdef IF1_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic [65:0] bus;
        logic [31:0] fc;
        logic [31:0] rc;
    } exp_t;
    exp_t sb[$];

    // Reference model state (16-entry BTB: index pc[5:2], tag pc[31:6])
    logic [31:0] m_pc;
    logic        m_v   [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [31:0] m_fc;
    logic [31:0] m_rc;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, push the model's expectation, compare at
    // negedge+1, then advance the model to the post-edge state.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] ba,
                       input logic we, input logic [31:0] bp, input logic [31:0] bt,
                       input logic tk);
        logic [3:0]  idx;
        logic [3:0]  uidx;
        logic        hit;
        logic [31:0] ptgt;
        logic        en;
        exp_t        e;
        @(negedge clk);
        rst = r; stall = {5'b0, s}; br_e = b; br_addr = ba;
        btb_we = we; btb_pc = bp; btb_target = bt; btb_taken = tk;
        idx  = m_pc[5:2];
        hit  = m_v[idx] && (m_tag[idx] == m_pc[31:6]);
        ptgt = hit ? m_tgt[idx] : m_pc + 32'd4;
        en   = !r && !s && !b;
        e.en   = en;
        e.addr = m_pc;
        e.bus  = {en, m_pc, hit, ptgt};
        e.fc   = m_fc;
        e.rc   = m_rc;
        sb.push_back(e);
        if (r) begin
            m_pc = RST_PC;
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
            m_fc = 0;
            m_rc = 0;
        end else begin
            if (en && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            if (b && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
            m_pc = b ? {ba[31:2], 2'b00} : (s ? m_pc : ptgt);
            if (we) begin
                uidx = bp[5:2];
                if (tk) begin
                    m_v[uidx]   = 1'b1;
                    m_tag[uidx] = bp[31:6];
                    m_tgt[uidx] = {bt[31:2], 2'b00};
                end else if (m_tag[uidx] == bp[31:6]) begin
                    m_v[uidx] = 1'b0;
                end
            end
        end
        #1;
        e = sb.pop_front();
        check("sram_en", {65'b0, inst_sram_en}, {65'b0, e.en});
        check("sram_we", {62'b0, inst_sram_we}, 66'b0);
        check("sram_addr", {34'b0, inst_sram_addr}, {34'b0, e.addr});
        check("bus", if12if2_bus, e.bus);
`ifdef IF1_PERF_CNT_EN
        check("perf_fetch", {34'b0, perf_fetch_cnt}, {34'b0, e.fc});
        check("perf_redirect", {34'b0, perf_redirect_cnt}, {34'b0, e.rc});
`endif
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic redir(input logic [31:0] a);
        cyc(0, 0, 1, a, 0, 0, 0, 0);
    endtask
    task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
        cyc(0, 0, 0, 0, 1, p, t, tk);
    endtask
    task automatic chk_addr(input string tag, input logic [31:0] a);
        check(tag, {34'b0, inst_sram_addr}, {34'b0, a});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; stall = '0; br_e = 0; br_addr = 0;
        btb_we = 0; btb_pc = 0; btb_target = 0; btb_taken = 0;
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        m_fc = 0; m_rc = 0;
        repeat (2) @(posedge clk);
        m_pc = RST_PC;

        // reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_valid", {65'b0, if12if2_bus[65]}, 66'b0);
        check("rst_pred_taken", {65'b0, if12if2_bus[32]}, 66'b0);

        // sequential fetch
        idle(); chk_addr("seq0", 32'h8000_0000);
        check("seq0_valid", {65'b0, if12if2_bus[65]}, 66'b1);
        idle(); idle(); idle(); chk_addr("seq3", 32'h8000_000C);

        // stall 3 cycles at 80000010
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk_addr("stall_hold", 32'h8000_0010);
        check("stall_en", {65'b0, inst_sram_en}, 66'b0);
        idle(); chk_addr("stall_resume", 32'h8000_0010);
        idle(); idle(); idle();

        // redirect at 80000020
        redir(32'h8000_0103); chk_addr("br_pc", 32'h8000_0020);
        check("br_valid", {65'b0, if12if2_bus[65]}, 66'b0);
        idle(); chk_addr("br_target", 32'h8000_0100);
        // redirect under stall
        cyc(0, 1, 1, 32'h8000_0103, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(); chk_addr("br_stall", 32'h8000_0100);

        // BTB install
        upd(32'h8000_0040, 32'h8000_0200, 1);
        redir(32'h8000_0040);
        idle(); chk_addr("btb_pc", 32'h8000_0040);
        check("btb_hit", {65'b0, if12if2_bus[32]}, 66'b1);
        check("btb_tgt", {34'b0, if12if2_bus[31:0]}, {34'b0, 32'h8000_0200});
        idle(); chk_addr("btb_follow", 32'h8000_0200);
        // alias invalidate leaves entry
        upd(32'h8000_1040, 32'h0, 0);
        redir(32'h8000_0040);
        idle(); check("alias_keep", {65'b0, if12if2_bus[32]}, 66'b1);
        idle(); chk_addr("alias_follow", 32'h8000_0200);
        // matching invalidate
        upd(32'h8000_0040, 32'h0, 0);
        redir(32'h8000_0040);
        idle(); check("inval", {65'b0, if12if2_bus[32]}, 66'b0);
        idle(); chk_addr("inval_seq", 32'h8000_0044);

        // same-cycle update and lookup: old data
        upd(32'h8000_0048, 32'h8000_0300, 1);
        check("same_cycle_old", {65'b0, if12if2_bus[32]}, 66'b0);
        idle(); chk_addr("same_cycle_seq", 32'h8000_004C);
        redir(32'h8000_0048);
        idle(); check("same_cycle_new", {34'b0, if12if2_bus[31:0]}, {34'b0, 32'h8000_0300});
        idle(); chk_addr("same_cycle_follow", 32'h8000_0300);

        // wrap-around
        redir(32'hFFFF_FFFC);
        idle(); chk_addr("wrap_pc", 32'hFFFF_FFFC);
        idle(); chk_addr("wrap_zero", 32'h0000_0000);

        // held redirect
        redir(32'h8000_0500);
        redir(32'h8000_0600); chk_addr("held_br1", 32'h8000_0500);
        idle(); chk_addr("held_br2", 32'h8000_0600);

        // reset mid-stream beats br_e, stall and btb_we
        cyc(1, 1, 1, 32'h8000_0700, 1, 32'h8000_0080, 32'h8000_0900, 1);
        idle(); chk_addr("mid_rst", RST_PC);
        redir(32'h8000_0048);
        idle(); check("rst_clr_btb", {65'b0, if12if2_bus[32]}, 66'b0);
        redir(32'h8000_0080);
        idle(); check("rst_blocks_we", {65'b0, if12if2_bus[32]}, 66'b0);
        repeat (7) idle();
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
`ifdef IF1_PERF_CNT_EN
        check("perf_fetch10", {34'b0, perf_fetch_cnt}, 66'd10);
        check("perf_redir2", {34'b0, perf_redirect_cnt}, 66'd2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("perf_clr", {2'b0, perf_fetch_cnt, perf_redirect_cnt}, 66'b0);
`endif
        check("sb_empty", 66'(sb.size()), 66'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
